// File: rtl/output_scheduler.sv
// output_scheduler: runs one classification trial over a bank of saturating
// output neurons. It releases the neuron reset on start, times the window,
// latches the first (lowest-index) saturating enabled neuron and holds the
// result until the host acknowledges it.
module output_scheduler #(
  parameter int NUM_OUT = 10,
  parameter int WINDOW  = 2048,
  parameter int CNT_W   = $clog2(WINDOW + 1)
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic                       ack,
  input  logic [NUM_OUT-1:0]         enable_mask,
  input  logic [NUM_OUT-1:0]         neuron_out,
  output logic                       neuron_rst_n,
  output logic                       busy,
  output logic                       done,
  output logic [$clog2(NUM_OUT)-1:0] winner,
  output logic                       timeout,
  output logic                       tie,
  output logic [CNT_W-1:0]           elapsed,
  output logic [15:0]                trial_count
);

  localparam int WIN_W = $clog2(NUM_OUT);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam logic [CNT_W-1:0] LAST = CNT_W'(WINDOW - 1);

  logic [1:0]         state;
  logic [NUM_OUT-1:0] hits;
  logic [WIN_W-1:0]   first_idx;
  logic               multi_hit;
  logic [15:0]        trial_cnt_q;

  // Status outputs are pure decodes of the state register, so they stay
  // registered with no input-to-output path.
  assign busy         = (state == RUN);
  assign done         = (state == DONE);
  assign neuron_rst_n = (state != IDLE);
  assign trial_count  = trial_cnt_q;

  // Priority pick of the lowest enabled saturated neuron and tie detect.
  always_comb begin
    hits      = neuron_out & enable_mask;
    first_idx = '0;
    for (int unsigned i = NUM_OUT; i > 0; i--) begin
      if (hits[i-1]) first_idx = WIN_W'(i - 1);
    end
    multi_hit = ((hits & (hits - 1'b1)) != '0);
  end

  // Trial FSM with result capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      winner  <= '0;
      timeout <= 1'b0;
      tie     <= 1'b0;
      elapsed <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state   <= RUN;
            winner  <= '0;
            timeout <= 1'b0;
            tie     <= 1'b0;
            elapsed <= '0;
          end
        end
        RUN: begin
          if (hits != '0) begin
            winner <= first_idx;
            tie    <= multi_hit;
            state  <= DONE;
          end else if (elapsed == LAST) begin
            timeout <= 1'b1;
            winner  <= '0;
            tie     <= 1'b0;
            state   <= DONE;
          end else begin
            elapsed <= elapsed + 1'b1;
          end
        end
        DONE: begin
          if (ack) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Completed-trial counter, bumped on the acknowledging edge; wraps naturally.
  always_ff @(posedge clk) begin
    if (rst) begin
      trial_cnt_q <= '0;
    end else if (state == DONE && ack) begin
      trial_cnt_q <= trial_cnt_q + 16'd1;
    end
  end

endmodule

// File: tb/tb_output_scheduler.sv
// Scoreboard bench for output_scheduler (NUM_OUT=4, WINDOW=20).
module tb_output_scheduler;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       ack = 1'b0;
  logic [3:0] enable_mask = 4'b1111;
  logic [3:0] neuron_out = 4'b0000;
  logic       neuron_rst_n, busy, done, timeout, tie;
  logic [1:0] winner;
  logic [4:0] elapsed;
  logic [15:0] trial_count;

  output_scheduler #(.NUM_OUT(4), .WINDOW(20)) dut (
    .clk(clk), .rst(rst), .start(start), .ack(ack),
    .enable_mask(enable_mask), .neuron_out(neuron_out),
    .neuron_rst_n(neuron_rst_n), .busy(busy), .done(done),
    .winner(winner), .timeout(timeout), .tie(tie),
    .elapsed(elapsed), .trial_count(trial_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0] w;
    logic       to;
    logic       ti;
    logic [4:0] el;
  } exp_t;

  exp_t exp_q[$];
  int vectors = 0;
  int miscompares = 0;
  logic done_q = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  // Monitor: compare the result on every rising edge of done.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst && done && !done_q) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_done", 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("winner", 32'(winner), 32'(e.w));
          chk("timeout", 32'(timeout), 32'(e.to));
          chk("tie", 32'(tie), 32'(e.ti));
          chk("elapsed", 32'(elapsed), 32'(e.el));
        end
      end
      done_q = done;
    end
  end

  // Pulse start; returns at the negedge inside RUN cycle 0.
  task automatic start_trial();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // From the current RUN cycle, wait k cycles then present a hit for one cycle.
  task automatic hit_at(input int k, input logic [3:0] no, input logic [3:0] mask);
    repeat (k) @(negedge clk);
    neuron_out  = no;
    enable_mask = mask;
    @(negedge clk);
    neuron_out = 4'b0000;
    chk("done_after_hit", 32'(done), 32'd1);
  endtask

  task automatic do_ack(input logic [15:0] tc_req);
    ack = 1'b1;
    @(negedge clk);
    ack = 1'b0;
    chk("ack_done", 32'(done), 32'd0);
    chk("ack_nrst", 32'(neuron_rst_n), 32'd0);
    chk("ack_tc", 32'(trial_count), 32'(tc_req));
  endtask

  initial begin
    int cnt;
    repeat (2) @(negedge clk);
    chk("rst_nrst", 32'(neuron_rst_n), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_winner", 32'(winner), 32'd0);
    chk("rst_timeout", 32'(timeout), 32'd0);
    chk("rst_tie", 32'(tie), 32'd0);
    chk("rst_elapsed", 32'(elapsed), 32'd0);
    chk("rst_tc", 32'(trial_count), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Single winner
    start_trial();
    chk("start_busy", 32'(busy), 32'd1);
    chk("start_nrst", 32'(neuron_rst_n), 32'd1);
    exp_q.push_back('{w: 2'd2, to: 1'b0, ti: 1'b0, el: 5'd5});
    hit_at(5, 4'b0100, 4'b1111);
    do_ack(16'd1);

    // Tie with mask
    start_trial();
    exp_q.push_back('{w: 2'd1, to: 1'b0, ti: 1'b1, el: 5'd3});
    hit_at(3, 4'b1011, 4'b1110);
    do_ack(16'd2);

    // Masked-off timeout; done rises exactly 20 cycles after busy
    enable_mask = 4'b0000;
    start_trial();
    exp_q.push_back('{w: 2'd0, to: 1'b1, ti: 1'b0, el: 5'd19});
    neuron_out = 4'b1111;
    cnt = 0;
    while (!done && cnt < 40) begin
      @(negedge clk);
      cnt++;
    end
    neuron_out = 4'b0000;
    chk("window_len", 32'(cnt), 32'd20);
    do_ack(16'd3);

    // Hit in last window cycle is a hit
    start_trial();
    exp_q.push_back('{w: 2'd3, to: 1'b0, ti: 1'b0, el: 5'd19});
    hit_at(19, 4'b1000, 4'b1111);
    do_ack(16'd4);

    // start during RUN and DONE ignored
    start_trial();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("run_start_elapsed", 32'(elapsed), 32'd1);
    exp_q.push_back('{w: 2'd0, to: 1'b0, ti: 1'b1, el: 5'd4});
    hit_at(3, 4'b0011, 4'b1111);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("done_start_done", 32'(done), 32'd1);
    chk("done_start_busy", 32'(busy), 32'd0);
    do_ack(16'd5);

    // ack in IDLE ignored; results persist in IDLE
    ack = 1'b1;
    @(negedge clk);
    ack = 1'b0;
    chk("idle_ack_tc", 32'(trial_count), 32'd5);
    chk("idle_winner_held", 32'(winner), 32'd0);
    chk("idle_tie_held", 32'(tie), 32'd1);

    // start+ack together in DONE
    start_trial();
    exp_q.push_back('{w: 2'd1, to: 1'b0, ti: 1'b0, el: 5'd0});
    hit_at(0, 4'b0010, 4'b1111);
    start = 1'b1;
    ack = 1'b1;
    @(negedge clk);
    start = 1'b0;
    ack = 1'b0;
    chk("sa_done", 32'(done), 32'd0);
    chk("sa_tc", 32'(trial_count), 32'd6);
    repeat (2) @(negedge clk);
    chk("sa_stay_idle", 32'(busy), 32'd0);
    chk("sa_tc_once", 32'(trial_count), 32'd6);

    // Reset in RUN cycle 7
    start_trial();
    repeat (7) @(negedge clk);
    chk("pre_rst_elapsed", 32'(elapsed), 32'd7);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mid_rst_nrst", 32'(neuron_rst_n), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_done", 32'(done), 32'd0);
    chk("mid_rst_tc", 32'(trial_count), 32'd0);
    start_trial();
    chk("restart_elapsed0", 32'(elapsed), 32'd0);
    @(negedge clk);
    chk("restart_elapsed1", 32'(elapsed), 32'd1);
    exp_q.push_back('{w: 2'd3, to: 1'b0, ti: 1'b0, el: 5'd3});
    hit_at(2, 4'b1000, 4'b1111);
    do_ack(16'd1);

    // Counter wrap
    force dut.trial_cnt_q = 16'hFFFF;
    @(negedge clk);
    release dut.trial_cnt_q;
    @(negedge clk);
    chk("forced_tc", 32'(trial_count), 32'hFFFF);
    start_trial();
    exp_q.push_back('{w: 2'd2, to: 1'b0, ti: 1'b0, el: 5'd0});
    hit_at(0, 4'b0100, 4'b1111);
    do_ack(16'h0000);

    repeat (2) @(negedge clk);
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/output_scheduler.md
# output_scheduler

Sequences one classification trial across a bank of NUM_OUT saturating output neurons. The neurons share a common active-low reset, which this block drives; each neuron raises `neuron_out` when its spike balance saturates. On `start` the block releases the neurons and times the evaluation window. It picks the first neuron to saturate, lowest index winning on a same-cycle tie, and holds the result for the host until acknowledged. It sits between the JTAG/host command logic and the output-neuron array.

## Interface
- `NUM_OUT`, 10: number of output neurons supervised.
- `WINDOW`, 2048: maximum RUN cycles before the trial times out. Must be ≥ 2.
- `CNT_W`, $clog2(WINDOW+1): width of `elapsed`.
- `clk`  in  1  system clock; all logic on posedge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  single-cycle trial request; honoured only in IDLE.
- `ack`  in  1  host acknowledges result; honoured only in DONE.
- `enable_mask`  in  NUM_OUT  1 = neuron participates; sampled each RUN cycle.
- `neuron_out`  in  NUM_OUT  saturation flags from the neuron array.
- `neuron_rst_n`  out  1  active-low reset to all neurons.
- `busy`  out  1  high in RUN.
- `done`  out  1  high in DONE; result outputs valid.
- `winner`  out  $clog2(NUM_OUT)  index of the winning neuron.
- `timeout`  out  1  trial ended with no enabled neuron saturated.
- `tie`  out  1  more than one enabled neuron saturated in the deciding cycle.
- `elapsed`  out  CNT_W  RUN cycle index at which the decision was made.
- `trial_count`  out  16  completed trials; wraps 0xFFFF→0.

## Operation
- States: IDLE, RUN, DONE. Reset state is IDLE.
- `neuron_rst_n` = 0 in IDLE and while `rst` is high. It = 1 in RUN and DONE, so neuron balances stay readable in DONE.
- IDLE:
  - `start`=1 → RUN.
  - On the transition, clear `elapsed`, `winner`, `timeout` and `tie`.
- RUN: each cycle, compute hits = `neuron_out` & `enable_mask`.
  - hits ≠ 0:
    - `winner` = lowest set index.
    - `tie` = (popcount(hits) > 1).
    - `elapsed` holds its current value.
    - → DONE.
  - hits = 0 and `elapsed` == WINDOW-1:
    - `timeout`=1, `winner`=0, `tie`=0.
    - `elapsed` stays WINDOW-1.
    - → DONE.
  - Otherwise, `elapsed` += 1.
  - A hit in the last window cycle counts as a hit, not a timeout.
- DONE:
  - Hold all result outputs.
  - `ack`=1 → IDLE, and `trial_count` += 1 on that edge.
  - Results stay on the outputs in IDLE until the next `start`.
- `start` outside IDLE is ignored. `ack` outside DONE is ignored.
- `start` and `ack` high together in DONE: `ack` is taken, `start` is ignored, and the block goes to IDLE.
- `rst` in any state, including mid-RUN:
  - Next state is IDLE.
  - All outputs return to reset values.
  - `trial_count` resets to 0.
- Changing `enable_mask` during RUN takes effect in the same cycle it changes.

## Timing
- Reset values:
  - `neuron_rst_n`=0, `busy`=0, `done`=0, `winner`=0.
  - `timeout`=0, `tie`=0, `elapsed`=0, `trial_count`=0.
- All outputs are registered; there is no combinational path from inputs to outputs.
- `start` sampled at edge t → `busy`=1 and `neuron_rst_n`=1 from t+1. The first RUN cycle has `elapsed`=0.
- A hit sampled in RUN cycle k (where `elapsed`=k) → at the next edge, `done`=1, `busy`=0 and `elapsed`=k.
- No hit → `done` rises after exactly WINDOW RUN cycles.
- `ack` sampled at edge a → `done`=0 and `neuron_rst_n`=0 from a+1. A new `start` is accepted from edge a+1 onward.
- Minimum trial turnaround: 3 cycles (IDLE→RUN→DONE→IDLE).

## Test plan
Use NUM_OUT=4 and WINDOW=20 unless stated otherwise.
1. Single winner:
   - Stimulus: `start`; assert `neuron_out`=4'b0100 in RUN cycle 5; mask = 4'b1111.
   - Required: `done`=1 next cycle; `winner`=2, `elapsed`=5, `tie`=0, `timeout`=0.
   - Then `ack`: `trial_count`=1, `neuron_rst_n`=0.
2. Tie and mask:
   - Stimulus: `neuron_out`=4'b1011 with mask=4'b1110 in RUN cycle 3.
   - Required: `winner`=1, `tie`=1, `elapsed`=3.
   - Repeat with mask=4'b0000 and no other stimulus: `timeout`=1 after 20 RUN cycles, `elapsed`=19, `winner`=0.
3. Window boundary:
   - Stimulus A: hit in RUN cycle 19 → required: `timeout`=0, `elapsed`=19.
   - Stimulus B: no hit → required: `done` rises exactly 20 cycles after `busy` rises.
4. Ignored controls:
   - `start` pulses during RUN and DONE → required: no effect.
   - `ack` in IDLE → required: `trial_count` unchanged.
   - `start` and `ack` together in DONE → required: block enters IDLE and stays there; `trial_count` increments once.
5. Reset mid-operation:
   - Stimulus: `rst` in RUN cycle 7 after two completed trials.
   - Required: next cycle shows IDLE with `neuron_rst_n`=0, `busy`=0, `done`=0, `trial_count`=0.
   - Then a new `start` → required: `elapsed` restarts at 0.
6. Counter wrap:
   - Stimulus: force `trial_count` to 0xFFFF, then complete one trial.
   - Required: `trial_count`=0x0000.
